dmem_responder: RTL and testbench

Memory-side responder for core data accesses. It accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, commits byte-enabled writes to an internal word array, and returns read data or an error over a second valid/ready channel. It replaces the zero-latency data memory array for multi-cycle and stall-capable cores.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dm_byte_ram.sv | 27 ++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus widths
// and the request payload latched at accept time.
package dmem_responder_pkg;

   localparam int unsigned WORD_WIDTH = 32;
   localparam int unsigned BE_WIDTH   = 4;
   localparam int unsigned CNT_WIDTH  = 4;

   typedef enum logic [1:0] {
      DMR_IDLE   = 2'd0,
      DMR_WAIT   = 2'd1,
      DMR_ACCESS = 2'd2,
      DMR_RESP   = 2'd3
   } dmr_state_e;

   typedef struct packed {
      logic                  wen;
      logic [WORD_WIDTH-1:0] addr;
      logic [WORD_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   be;
   } dmr_req_t;

   // Rejected when misaligned or when the word index falls past the array.
   function automatic logic dmr_addr_err(input logic [WORD_WIDTH-1:0] addr,
                                         input int unsigned depth_words);
      return (addr[1:0] != 2'b00) ||
             ({2'b00, addr[WORD_WIDTH-1:2]} >= WORD_WIDTH'(depth_words));
   endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Synchronous word array with per-byte write enables and a registered read.
module dm_byte_ram
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic [BE_WIDTH-1:0]   we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata
);

   logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

   // Contents are deliberately never reset; read returns the pre-write word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(BE_WIDTH); i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one load/store at a time, inserts wait
// states, performs the byte-enabled access and holds the response until taken.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [WORD_WIDTH-1:0] req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   input  logic [BE_WIDTH-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORD_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int unsigned ADDR_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_INIT =
      CNT_WIDTH'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   dmr_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   dmr_req_t              req_q, req_d;
   logic                  req_ready_d;
   logic                  rsp_valid_d;
   logic [WORD_WIDTH-1:0] rsp_rdata_d;
   logic                  rsp_err_d;

   logic                  access_err;
   logic [BE_WIDTH-1:0]   ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [WORD_WIDTH-1:0] ram_rdata;

   assign access_err = dmr_addr_err(req_q.addr, DEPTH_WORDS);

   // Address the RAM from the live request while idle so the word is already
   // read out by the ACCESS cycle even with zero wait states.
   assign ram_addr = (state_q == DMR_IDLE) ? req_addr[ADDR_WIDTH+1:2]
                                           : req_q.addr[ADDR_WIDTH+1:2];

   // Reset at the ACCESS edge must suppress the write.
   assign ram_we = (state_q == DMR_ACCESS && rst && req_q.wen && !access_err)
                   ? req_q.be : '0;

   dm_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (req_q.wdata),
      .rdata (ram_rdata)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;

      case (state_q)
         DMR_IDLE: begin
            if (req_valid && req_ready) begin
               req_d = '{wen: req_wen, addr: req_addr, wdata: req_wdata, be: req_be};
               if (WAIT_CYCLES > 0) begin
                  state_d = DMR_WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = DMR_ACCESS;
               end
            end
         end
         DMR_WAIT: begin
            if (cnt_q == '0) begin
               state_d = DMR_ACCESS;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         DMR_ACCESS: begin
            state_d     = DMR_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = access_err;
            rsp_rdata_d = (access_err || req_q.wen) ? '0 : ram_rdata;
         end
         DMR_RESP: begin
            if (rsp_ready) begin
               state_d     = DMR_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = DMR_IDLE;
      endcase

      req_ready_d = (state_d == DMR_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= DMR_IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus randomized
// loads/stores checked against a word-array reference model.
module tb_dmem_responder;

   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned W_MAIN = 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic [1:0]  lat_req_valid, lat_req_ready, lat_rsp_valid, lat_rsp_err;
   logic [31:0] lat_rdata [2];

   int          cyc = 0;
   int          acc_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          ready_mode = 0;
   int          rise_cyc = 0;
   logic        prev_valid = 1'b0;
   exp_t        exp_q[$];
   logic [31:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_MAIN)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   for (genvar g = 0; g < 2; g++) begin : g_lat
      dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(g == 0 ? 0 : 15)) u_lat (
         .clk(clk), .rst(rst),
         .req_valid(lat_req_valid[g]), .req_ready(lat_req_ready[g]), .req_wen(1'b0),
         .req_addr(32'h0000_0012), .req_wdata(32'h0), .req_be(4'hF),
         .rsp_valid(lat_rsp_valid[g]), .rsp_ready(1'b1),
         .rsp_rdata(lat_rdata[g]), .rsp_err(lat_rsp_err[g])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out at cycle %0d", nm, cyc);
   endtask

   // Cycle counter and accept counter sampled on the active edge.
   always @(posedge clk) begin
      cyc++;
      if (rst === 1'b1 && req_valid && req_ready) acc_cnt++;
   end

   // rsp_ready driver: 0 = always take, 1 = stall, other = random.
   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Reference model: compute the response and apply the store.
   function automatic exp_t model(input logic wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be, input int acc);
      exp_t e;
      int unsigned idx = addr / 4;
      e.acc   = acc;
      e.err   = (addr % 4 != 0) || (idx >= DEPTH);
      e.rdata = 32'h0;
      if (!e.err) begin
         if (wen) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            e.rdata = model_mem[idx];
         end
      end
      return e;
   endfunction

   // Monitor: pop and compare on every response handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst !== 1'b1) begin
         prev_valid = 1'b0;
      end else begin
         if (rsp_valid && !prev_valid) rise_cyc = cyc;
         prev_valid = rsp_valid;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_rsp: rdata %h err %b with empty scoreboard", rsp_rdata, rsp_err);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("rsp_latency", 32'(rise_cyc - e.acc), 32'(W_MAIN + 1));
            end
         end
      end
   end

   task automatic do_req(input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
      int n = 0;
      req_wen = wen; req_addr = addr; req_wdata = wdata; req_be = be;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      if (req_ready !== 1'b1) begin
         timeout("req_accept");
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      exp_q.push_back(model(wen, addr, wdata, be, cyc));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin @(posedge clk); #1; n++; end
      if (exp_q.size() != 0 || rsp_valid) timeout("drain");
   endtask

   task automatic measure(input int g, input int exp_edges);
      int n = 0;
      lat_req_valid[g] = 1'b1;
      while (lat_req_ready[g] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      lat_req_valid[g] = 1'b0;
      n = 0;
      while (lat_rsp_valid[g] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      chk($sformatf("lat_edges_w%0d", g == 0 ? 0 : 15), 32'(n), 32'(exp_edges));
      chk("lat_err", 32'(lat_rsp_err[g]), 32'd1);
      chk("lat_rdata", lat_rdata[g], 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      logic [31:0] a;
      rst = 1'b0;
      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      lat_req_valid = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Directed full, partial and error accesses
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      do_req(1'b0, 32'h10, 32'h0, 4'hF);
      do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001);
      do_req(1'b0, 32'h10, 32'h0, 4'h0);
      do_req(1'b0, 32'h12, 32'h0, 4'hF);
      do_req(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF);
      do_req(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF);
      do_req(1'b1, 32'h10, 32'h55555555, 4'h0);
      do_req(1'b0, 32'h10, 32'h0, 4'hF);
      drain();

      // Stall the response while a second request waits
      ready_mode = 1;
      base = acc_cnt;
      req_wen = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = 4'hF;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      exp_q.push_back(model(1'b0, 32'h10, 32'h0, 4'hF, cyc));
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_rdata", rsp_rdata, 32'hDEADBEAA);
         chk("hold_rsp_err", 32'(rsp_err), 32'd0);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      chk("hold_accepts", 32'(acc_cnt - base), 32'd1);
      ready_mode = 0;
      n = 0;
      while (acc_cnt - base < 2 && n < 50) begin @(posedge clk); #1; n++; end
      req_valid = 1'b0;
      if (acc_cnt - base >= 2) exp_q.push_back(model(1'b0, 32'h10, 32'h0, 4'hF, cyc));
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("hold_total_accepts", 32'(acc_cnt - base), 32'd2);

      // Accept-to-valid latency at the wait-state extremes
      measure(0, 1);
      measure(1, 16);

      // Reset during the ACCESS cycle of a store
      do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
      drain();
      req_wen = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
      chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_req_ready_after", 32'(req_ready), 32'd1);
      do_req(1'b0, 32'h20, 32'h0, 4'hF);
      drain();

      // Randomized traffic over a small window plus the top word
      for (int w = 0; w < 16; w++) do_req(1'b1, 32'(w * 4), $urandom, 4'hF);
      do_req(1'b1, 32'((DEPTH - 1) * 4), $urandom, 4'hF);
      ready_mode = 2;
      for (int t = 0; t < 150; t++) begin
         case ($urandom_range(0, 9))
            7:       a = 32'((DEPTH - 1) * 4);
            8:       a = 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            9:       a = ($urandom_range(0, 1) != 0) ? 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 1000))
                                                     : 32'hFFFF_FFFC;
            default: a = 32'(4 * $urandom_range(0, 15));
         endcase
         do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
      drain();
      ready_mode = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
